// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer
// Assembles two big-endian operands from the UART byte stream, latches the
// requested operation from the buttons, launches the shared ALU, waits for
// its done strobe and holds the result for the display. Also recovers from
// inter-byte timeouts, framing errors and divide-by-zero.
module calc_op_sequencer #(
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              rx_err,
    input  logic              addBut,
    input  logic              subBut,
    input  logic              multBut,
    input  logic              divBut,
    output logic              alu_start,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              alu_done,
    input  logic [31:0]       alu_result,
    input  logic              alu_div0,
    output logic [31:0]       result,
    output logic              result_valid,
    output logic              err,
    output logic              busy
);
    localparam int OP_BYTES = DATA_W / 8;
    localparam int CW       = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;
    localparam int TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(OP_BYTES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RX_A, S_RX_B, S_WAIT_OP, S_START, S_BUSY, S_DONE
    } state_t;

    // With single-byte operands the first byte already completes op_a.
    localparam state_t        FIRST_ST  = (OP_BYTES == 1) ? S_RX_B : S_RX_A;
    localparam logic [CW-1:0] FIRST_CNT = (OP_BYTES == 1) ? '0 : CW'(1);

    state_t            r_state, w_nxt;
    logic [DATA_W-1:0] r_op_a, r_op_b;
    logic [31:0]       r_result;
    logic              r_result_valid, r_err, r_op_pending;
    logic [1:0]        r_alu_op;
    logic [3:0]        r_but_q;
    logic [CW-1:0]     r_byte_cnt, w_cnt_nxt;
    logic [TW-1:0]     r_to_cnt;

    logic [3:0] w_but, w_edge;
    logic [1:0] w_edge_op;
    logic       w_edge_any, w_edge_ok;
    logic       w_byte, w_last, w_in_rx, w_to_hit;
    logic       w_load_a, w_shift_a, w_shift_b, w_abort, w_err, w_take, w_clr_rv;

    assign w_but      = {divBut, multBut, subBut, addBut};
    assign w_edge     = w_but & ~r_but_q;
    assign w_edge_any = |w_edge;
    // The operation must stay stable while the ALU owns it.
    assign w_edge_ok  = w_edge_any && (r_state != S_START) && (r_state != S_BUSY);
    // A framing error in the same cycle poisons the byte.
    assign w_byte     = rx_valid && !rx_err;
    assign w_last     = (r_byte_cnt == LAST_BYTE);
    assign w_in_rx    = (r_state == S_RX_A) || (r_state == S_RX_B);
    assign w_to_hit   = w_in_rx && (r_to_cnt == TO_LAST);

    // Button priority: add > sub > mult > div.
    always_comb begin
        w_edge_op = 2'b11;
        if (w_edge[0])      w_edge_op = 2'b00;
        else if (w_edge[1]) w_edge_op = 2'b01;
        else if (w_edge[2]) w_edge_op = 2'b10;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_nxt;
    end

    // Next state and datapath control strobes.
    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = r_byte_cnt;
        w_load_a  = 1'b0;
        w_shift_a = 1'b0;
        w_shift_b = 1'b0;
        w_abort   = 1'b0;
        w_err     = 1'b0;
        w_take    = 1'b0;
        w_clr_rv  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (rx_err) begin
                    w_abort = 1'b1;
                    w_err   = 1'b1;
                end else if (w_byte) begin
                    w_load_a  = 1'b1;
                    w_nxt     = FIRST_ST;
                    w_cnt_nxt = FIRST_CNT;
                end
            end
            S_RX_A, S_RX_B: begin
                if (rx_err || (!w_byte && w_to_hit)) begin
                    w_abort = 1'b1;
                    w_err   = 1'b1;
                end else if (w_byte) begin
                    w_shift_a = (r_state == S_RX_A);
                    w_shift_b = (r_state == S_RX_B);
                    w_cnt_nxt = w_last ? '0 : r_byte_cnt + 1'b1;
                    if (w_last) begin
                        if (r_state == S_RX_A)
                            w_nxt = S_RX_B;
                        else
                            w_nxt = (r_op_pending || w_edge_any) ? S_START : S_WAIT_OP;
                    end
                end
            end
            S_WAIT_OP: begin
                if (r_op_pending || w_edge_any) w_nxt = S_START;
            end
            S_START: w_nxt = S_BUSY;
            S_BUSY: begin
                if (alu_done) begin
                    w_take = 1'b1;
                    w_err  = alu_div0;
                    w_nxt  = S_DONE;
                end
            end
            S_DONE: begin
                if (rx_err) begin
                    w_err = 1'b1;
                end else if (w_byte) begin
                    w_load_a  = 1'b1;
                    w_clr_rv  = 1'b1;
                    w_nxt     = FIRST_ST;
                    w_cnt_nxt = FIRST_CNT;
                end
            end
            default: w_nxt = S_IDLE;
        endcase
        if (w_abort) begin
            w_nxt     = S_IDLE;
            w_cnt_nxt = '0;
        end
    end

    // Operands, pending operation, result and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op_a         <= '0;
            r_op_b         <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
            r_op_pending   <= 1'b0;
            r_alu_op       <= 2'b00;
            r_but_q        <= '0;
            r_byte_cnt     <= '0;
            r_to_cnt       <= '0;
        end else begin
            r_but_q    <= w_but;
            r_err      <= w_err;
            r_byte_cnt <= w_cnt_nxt;
            if (w_abort) begin
                r_op_a <= '0;
                r_op_b <= '0;
            end else begin
                if (w_load_a)       r_op_a <= DATA_W'(rx_byte);
                else if (w_shift_a) r_op_a <= (r_op_a << 8) | DATA_W'(rx_byte);
                if (w_shift_b)      r_op_b <= (r_op_b << 8) | DATA_W'(rx_byte);
            end
            // Timer runs only while a frame is half received; any byte restarts it.
            if (w_in_rx && !w_byte && !w_abort) r_to_cnt <= r_to_cnt + 1'b1;
            else                                r_to_cnt <= '0;
            if (w_take) begin
                r_result       <= alu_div0 ? 32'hFFFF_FFFF : alu_result;
                r_result_valid <= 1'b1;
                r_op_pending   <= 1'b0;
            end else begin
                if (w_clr_rv) r_result_valid <= 1'b0;
                if (w_edge_ok) begin
                    r_op_pending <= 1'b1;
                    r_alu_op     <= w_edge_op;
                end
            end
        end
    end

    assign alu_start    = (r_state == S_START);
    assign alu_op       = r_alu_op;
    assign op_a         = r_op_a;
    assign op_b         = r_op_b;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign err          = r_err;
    assign busy         = (r_state != S_IDLE) && (r_state != S_DONE);
endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb_calc_op_sequencer
// Directed scenarios plus randomized frames for calc_op_sequencer, with a
// behavioural ALU stand-in and an arithmetic reference for expected results.
module tb_calc_op_sequencer;
    localparam int DATA_W = 16;
    localparam int TO_CYC = 50;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic              rx_err = 1'b0;
    logic              addBut = 1'b0, subBut = 1'b0, multBut = 1'b0, divBut = 1'b0;
    logic              alu_start;
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] op_a, op_b;
    logic              alu_done = 1'b0;
    logic [31:0]       alu_result = 32'h0;
    logic              alu_div0 = 1'b0;
    logic [31:0]       result;
    logic              result_valid, err, busy;

    int n_checks = 0;
    int n_pass   = 0;

    // ALU stand-in state
    bit          alu_en = 1'b1;
    bit          force_done = 1'b0;
    bit          done_real = 1'b0;
    int          alu_wait = 0;
    int          n_starts = 0;
    int          err_cycles = 0;
    logic [1:0]  cap_op;
    logic [15:0] cap_a, cap_b;
    logic [31:0] pend_res;
    logic        pend_div0;

    calc_op_sequencer #(.DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_err(rx_err),
        .addBut(addBut), .subBut(subBut), .multBut(multBut), .divBut(divBut),
        .alu_start(alu_start), .alu_op(alu_op), .op_a(op_a), .op_b(op_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_div0(alu_div0),
        .result(result), .result_valid(result_valid), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ALU stand-in: captures operands on alu_start, answers after 1-4 cycles.
    always @(negedge clk) begin
        if (done_real) begin
            n_checks++;
            if (result_valid !== 1'b1 || result !== (pend_div0 ? 32'hFFFF_FFFF : pend_res))
                $display("FAIL done_latency: result_valid=%b result=%h want valid=1 result=%h",
                         result_valid, result, pend_div0 ? 32'hFFFF_FFFF : pend_res);
            else n_pass++;
        end
        done_real = 1'b0;
        alu_done  = 1'b0;
        alu_div0  = 1'b0;
        if (err === 1'b1) err_cycles++;
        if (alu_start === 1'b1) begin
            n_starts++;
            cap_op = alu_op;
            cap_a  = op_a;
            cap_b  = op_b;
            if (alu_en) alu_wait = $urandom_range(1, 4);
        end else if (alu_wait > 0) begin
            alu_wait--;
            if (alu_wait == 0) begin
                pend_div0 = 1'b0;
                case (cap_op)
                    2'b00: pend_res = 32'(cap_a) + 32'(cap_b);
                    2'b01: pend_res = 32'(cap_a) - 32'(cap_b);
                    2'b10: pend_res = 32'(cap_a) * 32'(cap_b);
                    default: begin
                        if (cap_b == 16'h0) begin
                            pend_div0 = 1'b1;
                            pend_res  = 32'h0BAD_0BAD;
                        end else pend_res = 32'(cap_a) / 32'(cap_b);
                    end
                endcase
                alu_done   = 1'b1;
                alu_result = pend_res;
                alu_div0   = pend_div0;
                done_real  = 1'b1;
            end
        end
        if (force_done) begin
            alu_done   = 1'b1;
            alu_result = 32'h0000_1234;
            force_done = 1'b0;
        end
    end

    // Reference: what the display should show for a completed operation.
    function automatic logic [31:0] ref_result(input int op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            0: return {16'h0, a} + {16'h0, b};
            1: return {16'h0, a} - {16'h0, b};
            2: return {16'h0, a} * {16'h0, b};
            default: return (b == 16'h0) ? 32'hFFFF_FFFF : {16'h0, a} / {16'h0, b};
        endcase
    endfunction

    function automatic logic [3:0] op_mask(input int op);
        return 4'b0001 << op;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        tick(gap);
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input int gap);
        send_byte(a[15:8], gap);
        send_byte(a[7:0], gap);
        send_byte(b[15:8], gap);
        send_byte(b[7:0], 0);
    endtask

    task automatic press(input logic [3:0] m);
        {divBut, multBut, subBut, addBut} = m;
        @(negedge clk);
        {divBut, multBut, subBut, addBut} = 4'b0000;
    endtask

    task automatic pulse_rx_err();
        rx_err = 1'b1;
        @(negedge clk);
        rx_err = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int k;
        k = 0;
        while (result_valid !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (result_valid !== 1'b1) $display("FAIL %s_wait: result_valid=%b want 1 within 200 cycles", name, result_valid);
        else n_pass++;
        tick(2);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({alu_start, result_valid, err, busy} !== 4'b0000)
            $display("FAIL reset_ctl: start/valid/err/busy=%b want 0000", {alu_start, result_valid, err, busy});
        else n_pass++;
        n_checks++;
        if (result !== 32'h0) $display("FAIL reset_result: got %h want 0", result);
        else n_pass++;
        n_checks++;
        if (op_a !== 16'h0 || op_b !== 16'h0 || alu_op !== 2'b00)
            $display("FAIL reset_ops: op_a=%h op_b=%h alu_op=%b want 0", op_a, op_b, alu_op);
        else n_pass++;
    endtask

    task automatic test_add();
        int s0, e0;
        s0 = n_starts; e0 = err_cycles;
        press(4'b0001);
        send_frame(16'd5, 16'd7, 0);
        wait_result("add");
        n_checks++;
        if (n_starts - s0 != 1) $display("FAIL add_starts: got %0d want 1", n_starts - s0);
        else n_pass++;
        n_checks++;
        if (cap_op !== 2'b00 || cap_a !== 16'd5 || cap_b !== 16'd7)
            $display("FAIL add_operands: op=%b a=%0d b=%0d want 00/5/7", cap_op, cap_a, cap_b);
        else n_pass++;
        n_checks++;
        if (result !== 32'd12 || result_valid !== 1'b1 || busy !== 1'b0)
            $display("FAIL add_result: result=%0d valid=%b busy=%b want 12/1/0", result, result_valid, busy);
        else n_pass++;
        n_checks++;
        if (err_cycles != e0) $display("FAIL add_err: err cycles %0d want 0", err_cycles - e0);
        else n_pass++;
    endtask

    task automatic test_late_op();
        int s0;
        s0 = n_starts;
        send_frame(16'd100, 16'd10, 1);
        tick(5);
        n_checks++;
        if (busy !== 1'b1 || n_starts != s0) $display("FAIL late_wait: busy=%b starts=%0d want 1/0", busy, n_starts - s0);
        else n_pass++;
        send_byte(8'hFF, 2);
        press(4'b1100);
        n_checks++;
        if (alu_start !== 1'b1) $display("FAIL late_start_latency: alu_start=%b want 1", alu_start);
        else n_pass++;
        wait_result("late");
        n_checks++;
        if (cap_op !== 2'b10 || cap_a !== 16'd100 || cap_b !== 16'd10)
            $display("FAIL late_operands: op=%b a=%0d b=%0d want 10/100/10", cap_op, cap_a, cap_b);
        else n_pass++;
        n_checks++;
        if (result !== 32'h3E8 || n_starts - s0 != 1)
            $display("FAIL late_result: result=%h starts=%0d want 3e8/1", result, n_starts - s0);
        else n_pass++;
    endtask

    task automatic test_div0();
        int e0;
        e0 = err_cycles;
        press(4'b1000);
        send_frame(16'd9, 16'd0, 0);
        wait_result("div0");
        n_checks++;
        if (result !== 32'hFFFF_FFFF || result_valid !== 1'b1 || cap_op !== 2'b11)
            $display("FAIL div0_result: result=%h valid=%b op=%b want ffffffff/1/11", result, result_valid, cap_op);
        else n_pass++;
        n_checks++;
        if (err_cycles - e0 != 1) $display("FAIL div0_err: err cycles %0d want 1", err_cycles - e0);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int e0;
        send_byte(8'h00, 0);
        tick(TO_CYC - 1);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) $display("FAIL timeout_early: err=%b busy=%b want 0/1", err, busy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0) $display("FAIL timeout_fire: err=%b busy=%b want 1/0", err, busy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || op_a !== 16'h0) $display("FAIL timeout_after: err=%b op_a=%h want 0/0", err, op_a);
        else n_pass++;
        e0 = err_cycles;
        press(4'b0010);
        send_frame(16'd2, 16'd3, 3);
        wait_result("sub");
        n_checks++;
        if (result !== 32'hFFFF_FFFF || cap_op !== 2'b01 || err_cycles != e0)
            $display("FAIL timeout_sub: result=%h op=%b errs=%0d want ffffffff/01/0", result, cap_op, err_cycles - e0);
        else n_pass++;
    endtask

    task automatic test_framing();
        int s0, e0;
        e0 = err_cycles;
        pulse_rx_err();
        tick(2);
        n_checks++;
        if (err_cycles - e0 != 1 || result_valid !== 1'b1 || busy !== 1'b0)
            $display("FAIL frame_done: errs=%0d valid=%b busy=%b want 1/1/0", err_cycles - e0, result_valid, busy);
        else n_pass++;
        press(4'b0001);
        send_byte(8'h00, 0); send_byte(8'h04, 0); send_byte(8'h00, 0);
        s0 = n_starts; e0 = err_cycles;
        pulse_rx_err();
        tick(2);
        n_checks++;
        if (err_cycles - e0 != 1 || busy !== 1'b0 || op_a !== 16'h0)
            $display("FAIL frame_abort: errs=%0d busy=%b op_a=%h want 1/0/0", err_cycles - e0, busy, op_a);
        else n_pass++;
        send_frame(16'd4, 16'd2, 0);
        wait_result("frame1");
        n_checks++;
        if (result !== 32'd6 || n_starts - s0 != 1) $display("FAIL frame_add: result=%0d starts=%0d want 6/1", result, n_starts - s0);
        else n_pass++;
        press(4'b0001);
        send_byte(8'h00, 0); send_byte(8'h04, 0); send_byte(8'h00, 0);
        s0 = n_starts; e0 = err_cycles;
        rx_valid = 1'b1; rx_byte = 8'h02; rx_err = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; rx_byte = 8'h00; rx_err = 1'b0;
        tick(3);
        n_checks++;
        if (busy !== 1'b0 || n_starts != s0 || err_cycles - e0 != 1)
            $display("FAIL frame_same_cycle: busy=%b starts=%0d errs=%0d want 0/0/1", busy, n_starts - s0, err_cycles - e0);
        else n_pass++;
        send_frame(16'd4, 16'd2, 1);
        wait_result("frame2");
        n_checks++;
        if (result !== 32'd6 || cap_b !== 16'd2) $display("FAIL frame_add2: result=%0d b=%0d want 6/2", result, cap_b);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        logic [31:0] exp;
        int op, other, mode, s0, e0, exp_err;
        for (int it = 0; it < 24; it++) begin
            op    = int'($urandom_range(0, 3));
            other = int'($urandom_range(0, 3));
            mode  = int'($urandom_range(0, 2));
            a = 16'($urandom);
            b = 16'($urandom);
            if (op == 3 && $urandom_range(0, 2) == 0) b = 16'h0000;
            exp     = ref_result(op, a, b);
            exp_err = (op == 3 && b == 16'h0) ? 1 : 0;
            s0 = n_starts; e0 = err_cycles;
            if (mode == 0) press(op_mask(op));
            if (mode == 2) press(op_mask(other));
            send_byte(a[15:8], int'($urandom_range(0, 20)));
            send_byte(a[7:0], int'($urandom_range(0, 20)));
            if (mode == 2) press(op_mask(op));
            send_byte(b[15:8], int'($urandom_range(0, 20)));
            send_byte(b[7:0], 0);
            if (mode == 1) begin
                tick(int'($urandom_range(0, 60)));
                press(op_mask(op));
            end
            wait_result($sformatf("rand%0d", it));
            n_checks++;
            if (result !== exp) $display("FAIL rand%0d_result: got %h want %h (op %0d a %h b %h)", it, result, exp, op, a, b);
            else n_pass++;
            n_checks++;
            if (cap_op !== 2'(op) || cap_a !== a || cap_b !== b)
                $display("FAIL rand%0d_operands: op=%b a=%h b=%h want %0d/%h/%h", it, cap_op, cap_a, cap_b, op, a, b);
            else n_pass++;
            n_checks++;
            if (n_starts - s0 != 1 || err_cycles - e0 != exp_err)
                $display("FAIL rand%0d_ctl: starts=%0d errs=%0d want 1/%0d", it, n_starts - s0, err_cycles - e0, exp_err);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        int s0, k;
        alu_en = 1'b0;
        s0 = n_starts;
        press(4'b0001);
        send_frame(16'h0102, 16'h0304, 0);
        k = 0;
        while (n_starts == s0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        tick(2);
        n_checks++;
        if (busy !== 1'b1 || n_starts == s0) $display("FAIL arst_busy: busy=%b starts=%0d want 1/1", busy, n_starts - s0);
        else n_pass++;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({alu_start, result_valid, err, busy} !== 4'b0000 || result !== 32'h0)
            $display("FAIL arst_now: start/valid/err/busy=%b result=%h want 0000/0",
                     {alu_start, result_valid, err, busy}, result);
        else n_pass++;
        n_checks++;
        if (op_a !== 16'h0 || op_b !== 16'h0 || alu_op !== 2'b00)
            $display("FAIL arst_ops: op_a=%h op_b=%h alu_op=%b want 0", op_a, op_b, alu_op);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        @(posedge clk);
        #1 force_done = 1'b1;
        tick(3);
        n_checks++;
        if (result !== 32'h0 || result_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL arst_stray_done: result=%h valid=%b busy=%b want 0/0/0", result, result_valid, busy);
        else n_pass++;
        alu_en = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(2);
        test_reset();
        test_add();
        test_late_op();
        test_div0();
        test_timeout();
        test_framing();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
Control FSM between the UART byte receiver and the arithmetic unit on the receiving FPGA. It assembles two DATA_W-bit operands from the serial byte stream and latches the requested operation from the four operation buttons. It then starts the shared ALU, waits for its done handshake, and holds the 32-bit result for the display driver. It owns inter-byte timeout, framing-error and divide-by-zero recovery.

Parameters:
DATA_W, 16, operand width in bits; must be a multiple of 8.
OP_BYTES, DATA_W/8, bytes per operand; derived, not overridden.
TIMEOUT_CYC, 1000000, maximum clk cycles allowed between bytes of one frame.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (0 = reset)
rx_valid  in  1  one-cycle strobe: rx_byte holds a received byte
rx_byte  in  8  received byte
rx_err  in  1  one-cycle strobe: framing/stop-bit error from the UART receiver
addBut  in  1  add request; level, already synchronised
subBut  in  1  subtract request
multBut  in  1  multiply request
divBut  in  1  divide request
alu_start  out  1  one-cycle pulse that launches the ALU
alu_op  out  2  00 add, 01 sub, 10 mult, 11 div; stable from alu_start until alu_done
op_a  out  DATA_W  first operand; stable while the ALU is busy
op_b  out  DATA_W  second operand
alu_done  in  1  one-cycle strobe: alu_result and alu_div0 are valid
alu_result  in  32  ALU result
alu_div0  in  1  qualifies alu_done: divisor was zero
result  out  32  last completed result
result_valid  out  1  result holds a fresh value
err  out  1  one-cycle error pulse
busy  out  1  high in every state except IDLE and DONE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; op_a, op_b, result = 0; alu_op=00; alu_start, result_valid, err = 0; op_pending=0; byte and timeout counters = 0.
- Buttons: rising-edge detected against a registered copy. Any edge sets op_pending=1 and loads alu_op. Simultaneous edges resolve by priority add > sub > mult > div. A later edge overwrites alu_op in IDLE, RX_A, RX_B and WAIT_OP only. Edges are ignored in START and BUSY.
- Operands: big-endian. The first byte of each operand is the MSB, shifted in as op = {op[DATA_W-9:0], rx_byte}.
- States:
  - IDLE: on rx_valid, load the byte into op_a, set byte count=1, go to RX_A.
  - RX_A: collect OP_BYTES bytes into op_a. After the last byte, go to RX_B.
  - RX_B: collect OP_BYTES bytes into op_b. After the last byte, go to START if op_pending=1, else WAIT_OP.
  - WAIT_OP: wait for op_pending. Incoming rx_valid bytes are dropped. The timeout counter does not run here.
  - START: drive alu_start=1 for exactly one cycle, then go to BUSY.
  - BUSY: on alu_done:
    - alu_div0=0: result<=alu_result.
    - alu_div0=1: result<=32'hFFFF_FFFF and err pulses.
    - Either way, result_valid<=1, op_pending<=0, go to DONE.
  - DONE: hold. On rx_valid, clear result_valid, load the byte into op_a, go to RX_A (same cycle as the IDLE path).
- Latency:
  - alu_start is asserted 1 cycle after the last op_b byte (op already pending), or 1 cycle after the button edge in WAIT_OP.
  - result and result_valid update 1 cycle after alu_done.
- Timeout: counter cleared on every accepted byte; counts only in RX_A and RX_B. On reaching TIMEOUT_CYC: err pulse, go to IDLE, operands and byte count cleared; op_pending and result are kept.
- rx_err in RX_A, RX_B or IDLE: err pulse, go to IDLE, partial operand discarded. In DONE: err pulse, stay in DONE. In other states: ignored.
- rx_valid and rx_err in the same cycle: rx_err wins and the byte is dropped.
- rx_valid while in START or BUSY: dropped, no err.
- alu_done outside BUSY: ignored.
- Reset mid-operation: immediate return to reset values. The ALU is expected to be reset by the same rst.

Test Plan:
- Add: press addBut; send bytes 00 05 00 07 -> one alu_start with alu_op=00, op_a=5, op_b=7; ALU model returns 12 -> result=12, result_valid=1, busy=0.
- Late op / priority: send 00 64 00 0A with no button -> WAIT_OP, no alu_start; assert multBut and divBut in the same cycle -> alu_op=10; result=1000 (0x3E8).
- Divide by zero: divBut; send 00 09 00 00; ALU returns alu_div0=1 -> result=32'hFFFF_FFFF, err high for exactly 1 cycle, result_valid=1.
- Timeout (TIMEOUT_CYC=50): send 00, then idle 50 cycles -> err pulse, state IDLE; next frame 00 02 00 03 with subBut -> result=32'hFFFF_FFFF (2-3, 32-bit two's complement from the ALU model).
- Framing error: rx_err after the 3rd byte -> err pulse, IDLE; fresh frame 00 04 00 02 with addBut -> result=6. Repeat with rx_valid and rx_err in the same cycle -> byte dropped.
- Async reset: assert rst=0 during BUSY, mid-cycle -> all outputs 0 immediately; alu_done after release -> ignored, result stays 0.
